// File: rtl/ram_burst_ctrl_pkg.sv
// ram_burst_ctrl_pkg: default widths, RAM depth and FSM encoding for ram_burst_ctrl
package ram_burst_ctrl_pkg;
    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_LEN_W = 4;
    localparam int MEM_DEPTH = 2**DEF_ADDR_W;
    typedef enum logic [1:0] {IDLE, WR, RD, FLUSH} state_e;
endpackage

// File: rtl/ram_burst_ctrl.sv
// ram_burst_ctrl: single/burst request front-end for a combinational-read RAM
// Define RAM_BURST_CTRL_BOUNDARY_ERR_EN to reject bursts crossing the top address (adds err).
module ram_burst_ctrl
    import ram_burst_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [DATA_W-1:0] wdata,
    output logic              rdata_valid,
    output logic [DATA_W-1:0] rdata,
    output logic              done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_wr,
    output logic              ram_cs,
`ifdef RAM_BURST_CTRL_BOUNDARY_ERR_EN
    output logic              err,
`endif
    input  logic [DATA_W-1:0] ram_data_out
);
    localparam logic [1:0] S_IDLE = IDLE, S_WR = WR, S_RD = RD, S_FLUSH = FLUSH;
    logic [1:0] state;
    logic [ADDR_W-1:0] cur_addr;
    logic [LEN_W-1:0] cnt;
    logic rd_iss, rd_last, last;
    assign req_ready = state == S_IDLE;
    assign wdata_ready = state == S_WR;
    assign last = cnt == '0;
`ifdef RAM_BURST_CTRL_BOUNDARY_ERR_EN
    logic [ADDR_W:0] end_addr;
    logic oob;
    assign end_addr = {1'b0, req_addr} + (ADDR_W+1)'(req_len);
    assign oob = end_addr[ADDR_W];
`endif
    // rd_iss -> rdata_valid is the read pipeline; done for reads rides on rd_last
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cur_addr <= '0;
            cnt <= '0;
            ram_addr <= '0;
            ram_data_in <= '0;
            ram_wr <= 1'b0;
            ram_cs <= 1'b0;
            rdata <= '0;
            rdata_valid <= 1'b0;
            done <= 1'b0;
            rd_iss <= 1'b0;
            rd_last <= 1'b0;
`ifdef RAM_BURST_CTRL_BOUNDARY_ERR_EN
            err <= 1'b0;
`endif
        end else begin
            ram_wr <= 1'b0;
            ram_cs <= 1'b0;
            rd_iss <= 1'b0;
            rd_last <= 1'b0;
            rdata_valid <= rd_iss;
            done <= rd_last;
            if (rd_iss) rdata <= ram_data_out;
`ifdef RAM_BURST_CTRL_BOUNDARY_ERR_EN
            err <= 1'b0;
`endif
            case (state)
                S_IDLE: if (req_valid) begin
                    cur_addr <= req_addr;
                    cnt <= req_len;
                    state <= req_wr ? S_WR : S_RD;
`ifdef RAM_BURST_CTRL_BOUNDARY_ERR_EN
                    if (oob) begin
                        state <= S_FLUSH;
                        done <= 1'b1;
                        err <= 1'b1;
                    end
`endif
                end
                S_WR: if (wdata_valid) begin
                    ram_addr <= cur_addr;
                    ram_data_in <= wdata;
                    ram_wr <= 1'b1;
                    ram_cs <= 1'b1;
                    cur_addr <= cur_addr + ADDR_W'(1);
                    cnt <= cnt - LEN_W'(1);
                    if (last) begin
                        state <= S_FLUSH;
                        done <= 1'b1;
                    end
                end
                S_RD: begin
                    ram_addr <= cur_addr;
                    ram_cs <= 1'b1;
                    rd_iss <= 1'b1;
                    cur_addr <= cur_addr + ADDR_W'(1);
                    cnt <= cnt - LEN_W'(1);
                    if (last) begin
                        rd_last <= 1'b1;
                        state <= S_FLUSH;
                    end
                end
                default: if (done) state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_burst_ctrl.sv
// tb_ram_burst_ctrl: directed bench for ram_burst_ctrl driving a 1024x8 RAM model
// Honours RAM_BURST_CTRL_BOUNDARY_ERR_EN when the DUT is built with it.
module tb_ram_burst_ctrl;
    logic clk = 1'b0, rst = 1'b1;
    logic req_valid = 1'b0, req_ready, req_wr = 1'b0;
    logic [9:0] req_addr = '0;
    logic [3:0] req_len = '0;
    logic wdata_valid = 1'b0, wdata_ready;
    logic [7:0] wdata = '0, rdata, ram_data_in, ram_data_out;
    logic rdata_valid, done, ram_wr, ram_cs;
    logic [9:0] ram_addr;
`ifdef RAM_BURST_CTRL_BOUNDARY_ERR_EN
    logic err;
`endif
    always #5 clk = ~clk;

    ram_burst_ctrl dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_len(req_len), .wdata_valid(wdata_valid),
        .wdata_ready(wdata_ready), .wdata(wdata), .rdata_valid(rdata_valid), .rdata(rdata),
        .done(done), .ram_addr(ram_addr), .ram_data_in(ram_data_in), .ram_wr(ram_wr),
        .ram_cs(ram_cs),
`ifdef RAM_BURST_CTRL_BOUNDARY_ERR_EN
        .err(err),
`endif
        .ram_data_out(ram_data_out)
    );

    logic [7:0] mem [1024];
    assign ram_data_out = mem[ram_addr];
    always @(posedge clk) if (ram_wr && ram_cs) mem[ram_addr] <= ram_data_in;

    typedef struct { int c; logic [7:0] d; } beat_t;
    typedef struct { logic [9:0] addr; logic [3:0] len; logic [7:0] base; logic [9:0] last_addr; logic [7:0] last_data; } vec_t;
    beat_t rq[$];
    int cyc, wr_cnt, cs_bad, done_cyc, tests, fails;
    logic [9:0] last_wr_addr;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (rdata_valid) rq.push_back('{c: cyc, d: rdata});
        if (done) done_cyc = cyc;
        if (ram_wr) begin
            wr_cnt++;
            last_wr_addr = ram_addr;
            if (!ram_cs) cs_bad++;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic accept(input logic wr, input logic [9:0] a, input logic [3:0] l, output int k);
        int n;
        n = 0;
        @(negedge clk);
        req_wr = wr;
        req_addr = a;
        req_len = l;
        req_valid = 1'b1;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept", int'(req_ready), 1);
        k = cyc;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wr_burst(input logic [9:0] a, input logic [3:0] l, input logic [7:0] base,
                            input logic [7:0] step, input logic [31:0] pat,
                            output logic [31:0] seq, output logic fin);
        int k, i, c;
        accept(1'b1, a, l, k);
        seq = '0;
        i = 0;
        c = 0;
        while (i <= int'(l) && c < 32) begin
            wdata_valid = pat[c];
            wdata = 8'(base + i * step);
            @(negedge clk);
            #1;
            seq = {seq[30:0], ram_wr};
            if (pat[c]) i++;
            c++;
        end
        wdata_valid = 1'b0;
        fin = done && ram_wr;
        c = 0;
        while (!req_ready && c < 10) begin
            @(negedge clk);
            c++;
        end
    endtask

    task automatic rd_burst(input logic [9:0] a, input logic [3:0] l, input logic [7:0] base, input logic [7:0] step);
        int k, b;
        b = rq.size();
        accept(1'b0, a, l, k);
        repeat (int'(l) + 4) @(negedge clk);
        #1;
        chk("rd_beats", rq.size() - b, int'(l) + 1);
        for (int i = 0; i <= int'(l) && b + i < rq.size(); i++) begin
            chk("rd_data", rq[b+i].d, 8'(base + i * step));
            chk("rd_cycle", rq[b+i].c, k + 3 + i);
        end
        chk("rd_done_cycle", done_cyc, k + 3 + int'(l));
        chk("rd_back_idle", int'(req_ready), 1);
    endtask

    initial begin
        vec_t tv[5];
        logic [31:0] seq;
        logic fin;
        int w0, k;
        int acc[$], dn[$];
        tv[0] = '{10'h005, 4'd0, 8'hA5, 10'h005, 8'hA5};
`ifdef RAM_BURST_CTRL_BOUNDARY_ERR_EN
        tv[1] = '{10'h3FC, 4'd3, 8'h01, 10'h3FF, 8'h04};
`else
        tv[1] = '{10'h3FE, 4'd3, 8'h01, 10'h001, 8'h04};
`endif
        tv[2] = '{10'h3F0, 4'd15, 8'h80, 10'h3FF, 8'h8F};
        tv[3] = '{10'h100, 4'd1, 8'hFE, 10'h101, 8'hFF};
        tv[4] = '{10'h3FF, 4'd0, 8'h5A, 10'h3FF, 8'h5A};
        repeat (2) @(negedge clk);
        chk("rst_req_ready", int'(req_ready), 1);
        chk("rst_wdata_ready", int'(wdata_ready), 0);
        chk("rst_ram_wr", int'(ram_wr), 0);
        chk("rst_ram_cs", int'(ram_cs), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_rdata_valid", int'(rdata_valid), 0);
        chk("rst_ram_addr", int'(ram_addr), 0);
        chk("rst_rdata", int'(rdata), 0);
        rst = 1'b0;
        @(negedge clk);
        for (int v = 0; v < 5; v++) begin
            w0 = wr_cnt;
            wr_burst(tv[v].addr, tv[v].len, tv[v].base, 8'd1, '1, seq, fin);
            chk("wr_done_with_last_strobe", int'(fin), 1);
            chk("wr_pulses", wr_cnt - w0, int'(tv[v].len) + 1);
            chk("wr_last_addr", int'(last_wr_addr), int'(tv[v].last_addr));
            chk("wr_mem_last", int'(mem[tv[v].last_addr]), int'(tv[v].last_data));
            rd_burst(tv[v].addr, tv[v].len, tv[v].base, 8'd1);
        end
        wr_burst(10'h010, 4'd3, 8'h11, 8'h11, '1, seq, fin);
        chk("mem_0x013", int'(mem[10'h013]), 8'h44);
        rd_burst(10'h010, 4'd3, 8'h11, 8'h11);
        // wdata_valid pattern 1,0,0,1: strobes follow handshakes one cycle later
        w0 = wr_cnt;
        wr_burst(10'h020, 4'd1, 8'hC0, 8'd1, 32'h9, seq, fin);
        chk("gap_strobe_seq", int'(seq), 32'h9);
        chk("gap_pulses", wr_cnt - w0, 2);
        chk("gap_mem0", int'(mem[10'h020]), 8'hC0);
        chk("gap_mem1", int'(mem[10'h021]), 8'hC1);
        chk("gap_last_addr", int'(last_wr_addr), 10'h021);
        chk("gap_done", int'(fin), 1);
`ifdef RAM_BURST_CTRL_BOUNDARY_ERR_EN
        w0 = wr_cnt;
        accept(1'b1, 10'h3FE, 4'd3, k);
        wdata_valid = 1'b1;
        chk("oob_err", int'(err), 1);
        chk("oob_done", int'(done), 1);
        repeat (4) @(negedge clk);
        wdata_valid = 1'b0;
        chk("oob_no_strobe", wr_cnt - w0, 0);
        chk("oob_idle", int'(req_ready), 1);
`endif
        wr_burst(10'h200, 4'd7, 8'h00, 8'h00, '1, seq, fin);
        accept(1'b1, 10'h200, 4'd7, k);
        wdata_valid = 1'b1;
        wdata = 8'hD0;
        @(negedge clk);
        #1 wdata = 8'hD1;
        @(negedge clk);
        #1 wdata = 8'hD2;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_ram_wr", int'(ram_wr), 0);
        chk("abort_ram_cs", int'(ram_cs), 0);
        chk("abort_wdata_ready", int'(wdata_ready), 0);
        wdata_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_req_ready", int'(req_ready), 1);
        chk("abort_mem200", int'(mem[10'h200]), 8'hD0);
        chk("abort_mem201", int'(mem[10'h201]), 8'hD1);
        chk("abort_mem202", int'(mem[10'h202]), 8'h00);
        chk("abort_mem203", int'(mem[10'h203]), 8'h00);
        // request held valid across two read bursts
        @(negedge clk);
        #1;
        req_wr = 1'b0;
        req_addr = 10'h005;
        req_len = 4'd0;
        req_valid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            if (done) dn.push_back(cyc);
            if (req_ready) acc.push_back(cyc);
            if (acc.size() == 2) break;
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        chk("b2b_accepts", acc.size(), 2);
        chk("b2b_dones", dn.size(), 1);
        if (acc.size() == 2 && dn.size() == 1) begin
            chk("b2b_spacing", acc[1] - acc[0], 4);
            chk("b2b_after_done", acc[1] - dn[0], 1);
        end
        repeat (8) @(negedge clk);
        chk("b2b_last_rdata", int'(rq[rq.size()-1].d), 8'hA5);
        chk("wr_implies_cs", cs_bad, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule
